// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard front end: pin conditioning, 11-bit frame receive, Set-2 make/break decode.
// Optional arrow-key mapping is compiled in with `define PS2_ARROW_KEYS_EN.
module ps2_key_ctrl #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ctrl_up,
  output logic       ctrl_left,
  output logic       ctrl_right,
  output logic       code_valid,
  output logic [7:0] code_out,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FW-1:0] r_fcnt;
  logic          r_fclk, r_fclk_prev;
  state_t        r_state, w_nstate;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_idle;
  logic          r_brk, r_ext, r_w_h, r_a_h, r_d_h;
  logic          w_fall, w_dat, w_good, w_err;
  logic          w_up_a, w_left_a, w_right_a;

  assign w_fall = r_fclk_prev & ~r_fclk;
  assign w_dat  = r_dat_s2;

  // Synchroniser plus run-length filter; filtered clock idles high out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_fcnt      <= '0;
      r_fclk      <= 1'b1;
      r_fclk_prev <= 1'b1;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_data;
      r_dat_s2    <= r_dat_s1;
      r_fclk_prev <= r_fclk;
      if (r_clk_s2 != r_fclk) begin
        if (r_fcnt == FW'(FILTER_LEN - 1)) begin
          r_fclk <= r_clk_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_good   = 1'b0;
    w_err    = 1'b0;
    if (r_state != IDLE && !w_fall && r_idle == TW'(TIMEOUT - 1)) begin
      w_nstate = IDLE;
      w_err    = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    if (!w_dat) w_nstate = DATA;
        DATA:    if (r_bit_cnt == 3'd7) w_nstate = PARITY;
        PARITY:  w_nstate = STOP;
        STOP: begin
          w_nstate = IDLE;
          if ((^r_shift ^ r_par) && w_dat) w_good = 1'b1;
          else                              w_err  = 1'b1;
        end
        default: w_nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_idle    <= '0;
    end else begin
      if (r_state == IDLE || w_fall) r_idle <= '0;
      else                           r_idle <= r_idle + 1'b1;
      if (w_fall) begin
        case (r_state)
          IDLE:    r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          PARITY:  r_par <= w_dat;
          default: ;
        endcase
      end
    end
  end

`ifdef PS2_ARROW_KEYS_EN
  logic r_up_h, r_left_h, r_right_h;
  assign w_up_a    = r_up_h;
  assign w_left_a  = r_left_h;
  assign w_right_a = r_right_h;
`else
  assign w_up_a    = 1'b0;
  assign w_left_a  = 1'b0;
  assign w_right_a = 1'b0;
`endif

  // Decode: F0/E0 are prefixes; any other byte consumes and clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      code_out   <= '0;
      r_brk      <= 1'b0;
      r_ext      <= 1'b0;
      r_w_h      <= 1'b0;
      r_a_h      <= 1'b0;
      r_d_h      <= 1'b0;
`ifdef PS2_ARROW_KEYS_EN
      r_up_h     <= 1'b0;
      r_left_h   <= 1'b0;
      r_right_h  <= 1'b0;
`endif
    end else begin
      code_valid <= w_good;
      frame_err  <= w_err;
      if (w_err) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (w_good) begin
        code_out <= r_shift;
        if (r_shift == 8'hF0) begin
          r_brk <= 1'b1;
        end else if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          if (!r_ext) begin
            case (r_shift)
              8'h1D:   r_w_h <= !r_brk;
              8'h1C:   r_a_h <= !r_brk;
              8'h23:   r_d_h <= !r_brk;
              default: ;
            endcase
          end
`ifdef PS2_ARROW_KEYS_EN
          else begin
            case (r_shift)
              8'h75:   r_up_h    <= !r_brk;
              8'h6B:   r_left_h  <= !r_brk;
              8'h74:   r_right_h <= !r_brk;
              default: ;
            endcase
          end
`endif
        end
      end
    end
  end

  assign ctrl_up    = r_w_h | w_up_a;
  assign ctrl_left  = r_a_h | w_left_a;
  assign ctrl_right = r_d_h | w_right_a;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: frames, prefixes, errors, timeout, glitch rejection.
module tb_ps2_key_ctrl;
  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       ctrl_up, ctrl_left, ctrl_right, code_valid, frame_err;
  logic [7:0] code_out;

  int checks = 0, errors = 0;
  int cyc = 0, t_fall = 0, t_err = 0;
  int n_valid = 0, n_err = 0, n_wide = 0;
  logic [7:0] last_code = '0;
  logic prev_v = 1'b0, prev_e = 1'b0;

  ps2_key_ctrl #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ctrl_up(ctrl_up), .ctrl_left(ctrl_left), .ctrl_right(ctrl_right),
    .code_valid(code_valid), .code_out(code_out), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_v <= code_valid;
    prev_e <= frame_err;
    if (code_valid) begin
      n_valid   <= n_valid + 1;
      last_code <= code_out;
    end
    if (frame_err) begin
      n_err <= n_err + 1;
      t_err <= cyc;
    end
    if ((code_valid && prev_v) || (frame_err && prev_e)) n_wide <= n_wide + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0; wait_cyc(3);
    ps2_clk = 1'b1; wait_cyc(10);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;  wait_cyc(HALF/2);
    ps2_clk = 1'b0; t_fall = cyc; wait_cyc(HALF);
    ps2_clk = 1'b1; wait_cyc(HALF/2);
  endtask

  // glitch_at >= 0 inserts three short clock glitches before that data bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_at);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_at) begin glitch(); glitch(); glitch(); end
      send_bit(b[i]);
    end
    send_bit(~^b ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i]);
  endtask

  task automatic good(input logic [7:0] b, input string tag);
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(b, 1'b0, 1'b0, -1);
    chk({tag, "_valid"}, n_valid - v0, 1);
    chk({tag, "_err"},   n_err - e0,   0);
    chk({tag, "_code"},  last_code,    b);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] arrow_exp;
    wait_cyc(5);
    chk("rst_outs", {ctrl_up, ctrl_left, ctrl_right, code_valid, frame_err, code_out}, 0);
    reset = 1'b1; wait_cyc(5);

    // Reset mid-frame discards the partial frame
    send_partial(8'hFF, 4);
    reset = 1'b0; wait_cyc(5);
    chk("midrst_outs", {ctrl_up, ctrl_left, ctrl_right, code_valid, frame_err, code_out}, 0);
    ps2_data = 1'b1; reset = 1'b1; wait_cyc(20);
    good(8'h1C, "a_make");
    chk("a_left", ctrl_left, 1);

    // Two keys held together, then release one
    good(8'h1D, "w_make");
    good(8'h23, "d_make");
    chk("w_d_held", {ctrl_up, ctrl_right}, 2'b11);
    good(8'hF0, "brk1");
    good(8'h1D, "w_brk");
    chk("w_rel", {ctrl_up, ctrl_right}, 2'b01);

    // Parity error
    good(8'hF0, "brk2");
    good(8'h1C, "a_brk");
    chk("a_rel", ctrl_left, 0);
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b0, -1);
    chk("par_err", n_err - e0, 1);
    chk("par_novalid", n_valid - v0, 0);
    chk("par_left", ctrl_left, 0);
    good(8'h1C, "a_again");
    chk("a_again_left", ctrl_left, 1);

    // Bad stop bit clears the pending break prefix
    good(8'hF0, "brk3");
    good(8'h23, "d_brk");
    chk("d_rel", ctrl_right, 0);
    good(8'hF0, "brk4");
    e0 = n_err;
    send_frame(8'h23, 1'b0, 1'b1, -1);
    chk("stop_err", n_err - e0, 1);
    good(8'h23, "d_after");
    chk("d_after_make", ctrl_right, 1);

    // Timeout after 5 bits
    v0 = n_valid; e0 = n_err;
    send_partial(8'h55, 4);
    for (int i = 0; i < TO + 100 && n_err == e0; i++) wait_cyc(1);
    chk("to_seen", n_err - e0, 1);
    chk("to_lat", ((t_err - t_fall) >= TO + 5) && ((t_err - t_fall) <= TO + 20), 1);
    chk("to_novalid", n_valid - v0, 0);
    wait_cyc(10);
    good(8'h1D, "w_after_to");
    chk("w_after_to_up", ctrl_up, 1);

    // Glitches mid-frame must not shift bits
    good(8'hF0, "brk5");
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b0, 2);
    chk("gl_valid", n_valid - v0, 1);
    chk("gl_err", n_err - e0, 0);
    chk("gl_code", last_code, 8'h1C);
    chk("gl_left", ctrl_left, 0);

    // Extended codes
    good(8'hF0, "brk6");
    good(8'h1D, "w_brk2");
    chk("up_clear", ctrl_up, 0);
    good(8'hE0, "ext1");
    good(8'h75, "up_make");
`ifdef PS2_ARROW_KEYS_EN
    arrow_exp = 8'd1;
`else
    arrow_exp = 8'd0;
`endif
    chk("arrow_up", ctrl_up, arrow_exp[0]);
    good(8'hE0, "ext2");
    good(8'hF0, "brk7");
    good(8'h75, "up_brk");
    chk("arrow_up_rel", ctrl_up, 0);
    chk("right_kept", ctrl_right, 1);

    chk("strobe_width", n_wide, 0);
    reset = 1'b0; wait_cyc(3);
    chk("final_rst", {ctrl_up, ctrl_left, ctrl_right, code_valid, frame_err}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
